// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM encoding, frame size,
// common keyboard command bytes and the frame builder.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // Bits after the start bit, LSB first: d0..d7, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one raw PS/2 pin plus a falling-edge detector
// on the synchronised level.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic [1:0] meta;
  logic       prev;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; the chain resets to the idle-high line level
  // so leaving reset cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 2'b11;
      prev <= 1'b1;
    end else begin
      meta <= {meta[0], din};
      prev <= meta[1];
    end
  end

  assign sync = meta[1];
  assign fall = prev & ~meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled transfer.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_inhibit,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe
);

  localparam int                INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0]  INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [3:0]        LAST_BIT = 4'(FRAME_BITS - 1);

  logic [2:0]            state;
  logic [FRAME_BITS-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic [INH_W-1:0]      inh_cnt;
  logic                  err;
  logic                  clk_sync;
  logic                  clk_fall;
  logic                  dat_sync;
  logic                  unused_dat_fall;
  logic                  timeout_hit;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ps2c_in),
    .sync  (clk_sync),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ps2d_in),
    .sync  (dat_sync),
    .fall  (unused_dat_fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_active;

  // Runs from the request-to-send cycle onward and ignores device clock edges.
  assign tmo_active = (state == ST_RTS) || (state == ST_SEND) ||
                      (state == ST_ACK) || (state == ST_WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (reset || !tmo_active) tmo_cnt <= '0;
    else                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = tmo_active && (tmo_cnt == TMO_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      inh_cnt <= '0;
      err     <= 1'b0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
    end else if (timeout_hit) begin
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      err     <= 1'b1;
      state   <= ST_DONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_start) begin
            shreg   <= ps2_frame(tx_data);
            bit_cnt <= '0;
            inh_cnt <= '0;
            err     <= 1'b0;
            ps2c_oe <= 1'b1;
            state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2d_oe <= 1'b1;
            state   <= ST_RTS;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        ST_RTS: begin
          ps2c_oe <= 1'b0;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          // Device samples on its rising edge, so data changes while clock is low.
          if (clk_fall) begin
            ps2d_oe <= ~shreg[0];
            shreg   <= {1'b1, shreg[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            err   <= dat_sync;
            state <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_sync && dat_sync) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_busy    = (state != ST_IDLE);
  assign rx_inhibit = tx_busy;
  assign tx_done    = (state == ST_DONE);
  assign tx_error   = tx_done & err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model.
// Build with PS2_TX_TIMEOUT_EN defined to exercise the watchdog path.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INHIBIT = 20;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, rx_inhibit, ps2c_oe, ps2d_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2c_in, ps2d_in;

  // Open-drain bus with pull-ups: a line is high unless someone pulls it low.
  assign ps2c_in = ~(ps2c_oe | dev_clk_low);
  assign ps2d_in = ~(ps2d_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .rx_inhibit (rx_inhibit),
    .ps2c_in    (ps2c_in),
    .ps2d_in    (ps2d_in),
    .ps2c_oe    (ps2c_oe),
    .ps2d_oe    (ps2d_oe)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   inh_mism = 0;
  int   done_pulses = 0;
  int   long_done = 0;
  int   exp_done = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_inhibit !== tx_busy) inh_mism <= inh_mism + 1;
    if (tx_done === 1'b1) begin
      done_pulses <= done_pulses + 1;
      if (prev_done) long_done <= long_done + 1;
    end
    prev_done <= tx_done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference frame as the device sees it: start, d0..d7, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tx_start = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic start_xfer(input logic [7:0] d);
    tx_data = d;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    tx_data = 8'($urandom);
    check("start_latency", {tx_busy, ps2c_oe, ps2d_oe}, 3'b110);
  endtask

  task automatic wait_rts(output int inh, output int rts_cyc, output bit ok);
    inh = 1;
    rts_cyc = -1;
    ok = 1'b0;
    for (int i = 0; i < INHIBIT + 50; i++) begin
      tick();
      if (ps2d_oe && rts_cyc < 0) rts_cyc = cyc;
      if (ps2c_in && !ps2d_in) begin
        ok = 1'b1;
        break;
      end
      if (ps2c_oe && !ps2d_oe) inh++;
    end
  endtask

  task automatic device_clock(output logic b);
    repeat (HALF) tick();
    dev_clk_low = 1'b1;
    repeat (HALF) tick();
    b = ps2d_in;
    dev_clk_low = 1'b0;
  endtask

  task automatic device_frame(output logic [10:0] f);
    f[0] = ps2d_in;
    for (int i = 1; i < 11; i++) device_clock(f[i]);
  endtask

  task automatic device_ack(input bit ack);
    logic b;
    dev_dat_low = ack;
    device_clock(b);
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit exp_err, output bit seen);
    seen = 1'b0;
    exp_done++;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, seen, 1'b1);
    if (seen) check({tag, "_err_lines"}, {tx_error, ps2c_oe, ps2d_oe}, {exp_err, 2'b00});
  endtask

  task automatic end_done(input string tag);
    tick();
    check({tag, "_exit"}, {tx_done, tx_busy}, 2'b00);
  endtask

  task automatic rts_and_frame(input string tag, input logic [7:0] d, output logic [10:0] f);
    int inh, rts_cyc;
    bit ok;
    wait_rts(inh, rts_cyc, ok);
    check({tag, "_rts"}, ok, 1'b1);
    check({tag, "_inhibit_len"}, inh, INHIBIT);
    device_frame(f);
    check({tag, "_frame"}, f, exp_frame(d));
  endtask

  task automatic full_xfer(input logic [7:0] d, input bit ack, input string tag);
    logic [10:0] f;
    bit seen;
    start_xfer(d);
    rts_and_frame(tag, d, f);
    device_ack(ack);
    wait_done(tag, !ack, seen);
    if (seen) end_done(tag);
    else do_reset();
  endtask

  initial begin
    logic [10:0] f;
    logic        b;
    logic [7:0]  d;
    bit          seen;
    int          inh, rts_cyc, snap;
    bit          ok;

    repeat (3) tick();
    check("reset_outputs", {tx_busy, tx_done, tx_error, rx_inhibit, ps2c_oe, ps2d_oe}, 6'b0);
    reset = 1'b0;
    tick();

    // Set-LEDs command, acknowledged.
    start_xfer(CMD_SET_LEDS);
    rts_and_frame("ed", CMD_SET_LEDS, f);
    check("ed_data_bits", f[8:1], 8'b1110_1101);
    check("ed_parity_stop", f[10:9], 2'b11);
    device_ack(1'b1);
    wait_done("ed", 1'b0, seen);
    end_done("ed");

    // 0x01 with a stray start while busy, then 0xFF requested in the DONE cycle.
    start_xfer(8'h01);
    wait_rts(inh, rts_cyc, ok);
    check("b2b_rts", ok, 1'b1);
    tx_data = CMD_RESET;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    device_frame(f);
    check("b2b_frame01", f, exp_frame(8'h01));
    check("b2b_parity01", f[9], 1'b0);
    device_ack(1'b1);
    wait_done("b2b01", 1'b0, seen);
    tx_data = CMD_RESET;
    tx_start = 1'b1;
    tick();
    check("start_in_done_ignored", {tx_busy, tx_done}, 2'b00);
    tick();
    tx_start = 1'b0;
    check("start_after_done", {tx_busy, ps2c_oe}, 2'b11);
    rts_and_frame("b2bff", CMD_RESET, f);
    check("b2b_parityff", f[9], 1'b1);
    device_ack(1'b1);
    wait_done("b2bff", 1'b0, seen);
    end_done("b2bff");

    // Device leaves data high at the 11th clock.
    full_xfer(8'($urandom), 1'b0, "nack");

    // Reset in the middle of 0xAA, then a clean 0x55.
    start_xfer(8'hAA);
    wait_rts(inh, rts_cyc, ok);
    check("rst_rts", ok, 1'b1);
    for (int i = 0; i < 4; i++) device_clock(b);
    snap = done_pulses;
    reset = 1'b1;
    tick();
    check("reset_mid", {tx_busy, tx_done, tx_error, rx_inhibit, ps2c_oe, ps2d_oe}, 6'b0);
    reset = 1'b0;
    repeat (5) tick();
    check("reset_no_done", done_pulses, snap);
    full_xfer(8'h55, 1'b1, "after_reset");

    // Random bytes, mostly acknowledged.
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      full_xfer(d, ($urandom_range(0, 3) != 0), $sformatf("rnd%0d", i));
    end

    // Device never clocks.
    start_xfer(8'h3C);
    wait_rts(inh, rts_cyc, ok);
    check("tmo_rts", ok, 1'b1);
`ifdef PS2_TX_TIMEOUT_EN
    exp_done++;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 200; i++) begin
      if (tx_done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("tmo_done", seen, 1'b1);
    check("tmo_delay", cyc - rts_cyc, TIMEOUT);
    check("tmo_err_lines", {tx_error, ps2c_oe, ps2d_oe}, 3'b100);
    end_done("tmo");
`else
    snap = done_pulses;
    repeat (TIMEOUT + 200) tick();
    check("no_tmo_busy", tx_busy, 1'b1);
    check("no_tmo_done", done_pulses, snap);
    do_reset();
`endif

    check("done_count", done_pulses, exp_done);
    check("done_width", long_done, 0);
    check("rx_inhibit_track", inh_mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the opposite direction of the keyboard receiver path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs for caps-lock indication from the cipher FSM.
- Drives PS2_KBCLK/PS2_KBDAT open-drain through top-level tristates.
- Asserts rx_inhibit so the keyboard receiver ignores line activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the clock line is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: watchdog limit in clk cycles (15 ms). Used only with PS2_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (CLOCK_50 at top).
- reset  in  1  synchronous, active-high reset (top drives ~KEY[0]).
- tx_data  in  8  byte to send; sampled when tx_start is accepted.
- tx_start  in  1  single-cycle request; accepted only in IDLE.
- tx_busy  out  1  high from the acceptance cycle until DONE/ERR exits.
- tx_done  out  1  one-cycle pulse at the end of every transfer, success or fail.
- tx_error  out  1  valid with tx_done: 1 = NACK or timeout.
- rx_inhibit  out  1  equals tx_busy; gates the keyboard receiver.
- ps2c_in  in  1  raw PS/2 clock pin (async).
- ps2d_in  in  1  raw PS/2 data pin (async).
- ps2c_oe  out  1  1 = pull clock low; 0 = release.
- ps2d_oe  out  1  1 = pull data low; 0 = release.

Behaviour:
- Reset values: all outputs 0, lines released, state IDLE, counters 0. Reset asserted mid-transfer aborts immediately with no tx_done pulse.
- Input sync: ps2c_in and ps2d_in each pass through 2 flops. fall = prev & ~cur on the synced clock, giving 3-cycle detection latency.
- Frame: shift register {stop=1, parity, d7..d0}. Parity is odd: ~^tx_data. Data goes out LSB first.
- States:
  - IDLE: on tx_start, latch data and bit_cnt=0, set busy → INHIBIT.
  - INHIBIT: ps2c_oe=1 for INHIBIT_CYCLES cycles, then ps2d_oe=1 (start bit) → RTS.
  - RTS: one cycle, release clock (ps2c_oe=0) while keeping data low → SEND.
  - SEND: on each fall, ps2d_oe = ~next bit and bit_cnt++.
    - Falls 1–8 put out d0..d7.
    - Fall 9 puts out parity.
    - Fall 10 puts out stop, i.e. data released.
    - After fall 10 → ACK.
  - ACK: on the next fall (11th), sample synced data. 0 = ack ok; 1 = NACK, set err flag → WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock=1 and data=1 → DONE.
  - DONE: pulse tx_done, drive tx_error=err flag, clear busy → IDLE.
- Events arriving while busy:
  - tx_start is ignored; tx_data changes have no effect after latch.
  - tx_start in the same cycle as DONE is ignored; it is accepted the next cycle.
- The host never drives a line high; oe=0 means high-Z, and the top level supplies the pull-up.
- Latency from tx_start to first line change (ps2c_oe=1): 1 cycle.

Optional Feature:
- PS2_TX_TIMEOUT_EN defined:
  - A counter starts on leaving INHIBIT and runs through SEND, ACK and WAIT_IDLE; it does not reset on clock edges.
  - If it reaches TIMEOUT_CYCLES: release both lines, set err flag → DONE (tx_done pulse, tx_error=1).
- Undefined: no watchdog logic. The FSM waits indefinitely for device clocks, and tx_error indicates NACK only.

Decomposition:
- Package ps2_pkg holds:
  - the state encoding (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE);
  - FRAME_BITS=10;
  - command constants CMD_SET_LEDS=8'hED and CMD_RESET=8'hFF.
- Sub-module ps2_line_sync: 2-flop synchroniser plus fall detector. Instantiated twice: data uses only the synced output, clock also uses fall.

Test Plan (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, behavioural device model clocking at 40 clk/half-period):
- Send 0xED; device acks → device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulse with tx_error=0; ps2c_oe held 20 cycles first.
- Send 0x01, then 0xFF back-to-back → parity bits 0 then 1; second tx_start asserted while busy is ignored and only accepted after DONE.
- Device leaves data high at the 11th fall (NACK) → tx_done=1, tx_error=1; lines released.
- Reset asserted at bit 4 of 0xAA → next cycle all outputs 0 and state IDLE; a subsequent 0x55 transfer completes correctly.
- With PS2_TX_TIMEOUT_EN, device never clocks → tx_done and tx_error=1 exactly 2000 cycles after RTS. Without the macro, busy stays high.
- rx_inhibit tracks tx_busy cycle-for-cycle across all of the above.
